fft_butterfly_r4: RTL

Pipelined radix-4 DIT butterfly that sits directly downstream of the twiddle-multiply stage. It consumes the four twiddled complex samples from that stage and produces the four radix-4 outputs. Each output is scaled by a per-sample selectable right shift with rounding and saturation, which keeps the in-place FFT word width constant across stages. A sticky overflow flag reports any saturation.

---
 rtl/fft_butterfly_r4.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fft_butterfly_r4.sv
// fft_butterfly_r4: 3-stage radix-4 DIT butterfly with per-sample rounding shift, saturation and sticky overflow
module fft_butterfly_r4 #(
  parameter int D_BIT = 17
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iVALID,
  input  logic [1:0]              iSHIFT,
  input  logic                    iCLR_OVF,
  input  logic signed [D_BIT-1:0] iX0_RE,
  input  logic signed [D_BIT-1:0] iX0_IM,
  input  logic signed [D_BIT-1:0] iX1_RE,
  input  logic signed [D_BIT-1:0] iX1_IM,
  input  logic signed [D_BIT-1:0] iX2_RE,
  input  logic signed [D_BIT-1:0] iX2_IM,
  input  logic signed [D_BIT-1:0] iX3_RE,
  input  logic signed [D_BIT-1:0] iX3_IM,
  output logic                    oVALID,
  output logic signed [D_BIT-1:0] oY0_RE,
  output logic signed [D_BIT-1:0] oY0_IM,
  output logic signed [D_BIT-1:0] oY1_RE,
  output logic signed [D_BIT-1:0] oY1_IM,
  output logic signed [D_BIT-1:0] oY2_RE,
  output logic signed [D_BIT-1:0] oY2_IM,
  output logic signed [D_BIT-1:0] oY3_RE,
  output logic signed [D_BIT-1:0] oY3_IM,
  output logic                    oOVF
);
  localparam int W1 = D_BIT + 1;
  localparam int W2 = D_BIT + 2;
  localparam int W3 = D_BIT + 3;
  localparam logic signed [W3-1:0] MAXV = W3'((1 << (D_BIT - 1)) - 1);
  localparam logic signed [W3-1:0] MINV = ~MAXV;
  logic                   s1_v, s2_v;
  logic [1:0]             s1_sh, s2_sh;
  logic signed [W1-1:0]   s1 [8];
  logic signed [W2-1:0]   s2 [8];
  logic signed [W3-1:0]   rnd [8];
  logic signed [W3-1:0]   shv [8];
  logic signed [D_BIT-1:0] r [8];
  logic [7:0]             sat;
  // s1 layout: a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s1_v  <= 1'b0;
      s1_sh <= '0;
      s1    <= '{default: '0};
    end else begin
      s1_v <= iVALID;
      if (iVALID) begin
        s1_sh <= (iSHIFT == 2'd3) ? 2'd2 : iSHIFT;
        s1[0] <= W1'(iX0_RE) + W1'(iX2_RE);
        s1[1] <= W1'(iX0_IM) + W1'(iX2_IM);
        s1[2] <= W1'(iX0_RE) - W1'(iX2_RE);
        s1[3] <= W1'(iX0_IM) - W1'(iX2_IM);
        s1[4] <= W1'(iX1_RE) + W1'(iX3_RE);
        s1[5] <= W1'(iX1_IM) + W1'(iX3_IM);
        s1[6] <= W1'(iX1_RE) - W1'(iX3_RE);
        s1[7] <= W1'(iX1_IM) - W1'(iX3_IM);
      end
    end
  end
  // s2 layout: y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s2_v  <= 1'b0;
      s2_sh <= '0;
      s2    <= '{default: '0};
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sh <= s1_sh;
        s2[0] <= W2'(s1[0]) + W2'(s1[4]);
        s2[1] <= W2'(s1[1]) + W2'(s1[5]);
        s2[2] <= W2'(s1[2]) + W2'(s1[7]);
        s2[3] <= W2'(s1[3]) - W2'(s1[6]);
        s2[4] <= W2'(s1[0]) - W2'(s1[4]);
        s2[5] <= W2'(s1[1]) - W2'(s1[5]);
        s2[6] <= W2'(s1[2]) - W2'(s1[7]);
        s2[7] <= W2'(s1[3]) + W2'(s1[6]);
      end
    end
  end
  // shift is 0..2 here, so the half-LSB rounding constant equals the shift value itself
  always_comb begin
    sat = '0;
    for (int i = 0; i < 8; i++) begin
      rnd[i] = W3'(s2[i]) + W3'($signed({1'b0, s2_sh}));
      shv[i] = rnd[i] >>> s2_sh;
      sat[i] = (shv[i] > MAXV) || (shv[i] < MINV);
      r[i]   = (shv[i] > MAXV) ? D_BIT'(MAXV) : (shv[i] < MINV) ? D_BIT'(MINV) : D_BIT'(shv[i]);
    end
  end
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oVALID <= 1'b0;
      oOVF   <= 1'b0;
      oY0_RE <= '0;
      oY0_IM <= '0;
      oY1_RE <= '0;
      oY1_IM <= '0;
      oY2_RE <= '0;
      oY2_IM <= '0;
      oY3_RE <= '0;
      oY3_IM <= '0;
    end else begin
      oVALID <= s2_v;
      oOVF   <= (s2_v && |sat) ? 1'b1 : iCLR_OVF ? 1'b0 : oOVF;
      if (s2_v) begin
        oY0_RE <= r[0];
        oY0_IM <= r[1];
        oY1_RE <= r[2];
        oY1_IM <= r[3];
        oY2_RE <= r[4];
        oY2_IM <= r[5];
        oY3_RE <= r[6];
        oY3_IM <= r[7];
      end
    end
  end
endmodule
